// File: rtl/instr_fetch.sv
// Instruction fetch stage and IF/ID pipeline register.
// Holds the fetch PC, runs the imem req/ack handshake, parks an instruction
// in a skid register across decode stalls, and absorbs redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        valid
);

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StHeld = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e      state;
  logic [31:0] fpc;
  logic [31:0] skid;
  logic [31:0] skid_pc;
  logic [31:0] target;
  logic [31:0] fpc_inc;
  logic [31:0] skid_pc_inc;
  logic        acked;

  assign target      = {redirect_pc[31:2], 2'b00};
  assign fpc_inc     = fpc + 32'd4;
  assign skid_pc_inc = skid_pc + 32'd4;
  // imem_req is low in the first cycle after reset, so an ack there is ignored.
  assign acked       = imem_req & imem_ack;

  // Fetch FSM, fetch PC, skid buffer and registered IF/ID / imem outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StReq;
      fpc       <= RESET_PC;
      skid      <= 32'h0;
      skid_pc   <= 32'h0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      instr     <= 32'h0;
      pc        <= 32'h0;
      npc       <= 32'h0;
      valid     <= 1'b0;
    end else if (redirect) begin
      fpc   <= target;
      instr <= 32'h0;
      valid <= 1'b0;
      if (state == StDrop && !imem_ack) begin
        // Abandoned request still pending: keep its address until it acks.
        state <= StDrop;
      end else if (state == StReq && imem_req && !imem_ack) begin
        state <= StDrop;
      end else begin
        state     <= StReq;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
    end else begin
      case (state)
        StReq: begin
          imem_req <= 1'b1;
          if (acked) begin
            fpc       <= fpc_inc;
            imem_addr <= fpc_inc;
            if (stall) begin
              skid     <= imem_rdata;
              skid_pc  <= fpc;
              state    <= StHeld;
              imem_req <= 1'b0;
            end else begin
              instr <= imem_rdata;
              pc    <= fpc;
              npc   <= fpc_inc;
              valid <= 1'b1;
            end
          end else if (!stall) begin
            // Bubble; pc/npc keep their previous values.
            instr <= 32'h0;
            valid <= 1'b0;
          end
        end
        StHeld: begin
          if (!stall) begin
            instr    <= skid;
            pc       <= skid_pc;
            npc      <= skid_pc_inc;
            valid    <= 1'b1;
            state    <= StReq;
            imem_req <= 1'b1;
          end
        end
        StDrop: begin
          instr <= 32'h0;
          valid <= 1'b0;
          if (imem_ack) begin
            state     <= StReq;
            imem_addr <= fpc;
          end
        end
        default: begin
          state <= StReq;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a wait-state memory model.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        valid;

  // Second instance exercising PC wrap from the top of the address space.
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] npc2;
  logic        valid2;

  int wait_states;
  int wcnt;
  int n_cmp;
  int n_err;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .pc         (pc),
    .npc        (npc),
    .valid      (valid)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (1'b0),
    .redirect   (1'b0),
    .redirect_pc(32'h0),
    .imem_req   (imem_req2),
    .imem_addr  (imem_addr2),
    .imem_rdata (imem_addr2),
    .imem_ack   (imem_req2),
    .instr      (instr2),
    .pc         (pc2),
    .npc        (npc2),
    .valid      (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns its address as data after wait_states cycles.
  assign imem_ack   = imem_req && (wcnt == wait_states);
  assign imem_rdata = imem_addr;

  // Wait-state counter for the outstanding request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else        wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset, then release one cycle before "edge 1".
  task automatic do_reset(input int ws, input bit check_async);
    rst_n = 1'b0;
    #1;
    if (check_async) begin
      check("async_rst_valid", {31'b0, valid}, 32'h0);
      check("async_rst_req",   {31'b0, imem_req}, 32'h0);
      check("async_rst_instr", instr, 32'h0);
    end
    wait_states = ws;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    wait_states = 0;
    step();
    step();
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_npc",   npc, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_req",   {31'b0, imem_req}, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

    // Zero-wait streaming, plus wrap on the second instance.
    rst_n = 1'b1;
    step();
    check("zw_e1_req",   {31'b0, imem_req}, 32'h1);
    check("zw_e1_valid", {31'b0, valid}, 32'h0);
    check("wrap_e1_addr", imem_addr2, 32'hFFFF_FFFC);
    for (int e = 2; e <= 7; e++) begin
      step();
      check("zw_instr", instr, 32'(4 * (e - 2)));
      check("zw_pc",    pc, 32'(4 * (e - 2)));
      check("zw_npc",   npc, 32'(4 * (e - 1)));
      check("zw_valid", {31'b0, valid}, 32'h1);
      if (e == 2) begin
        check("wrap_e2_addr",  imem_addr2, 32'h0);
        check("wrap_e2_instr", instr2, 32'hFFFF_FFFC);
        check("wrap_e2_npc",   npc2, 32'h0);
      end
    end

    // Two wait states: one valid slot then two bubbles, address held until ack.
    do_reset(2, 1'b1);
    step();
    check("w2_e1_addr", imem_addr, 32'h0);
    for (int e = 2; e <= 10; e++) begin
      bit v;
      step();
      v = (e >= 4) && (e % 3 == 1);
      check("w2_valid", {31'b0, valid}, {31'b0, v});
      check("w2_instr", instr, v ? 32'(4 * ((e - 4) / 3)) : 32'h0);
      check("w2_addr",  imem_addr, 32'(4 * ((e - 1) / 3)));
    end

    // Stall while the 0x10 fetch acks.
    do_reset(0, 1'b0);
    for (int e = 1; e <= 5; e++) step();
    check("st_pre_instr", instr, 32'h0C);
    stall = 1'b1;
    for (int e = 6; e <= 8; e++) begin
      step();
      check("st_hold_instr", instr, 32'h0C);
      check("st_hold_pc",    pc, 32'h0C);
      check("st_hold_valid", {31'b0, valid}, 32'h1);
      check("st_hold_req",   {31'b0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    step();
    check("st_rel_instr", instr, 32'h10);
    check("st_rel_pc",    pc, 32'h10);
    check("st_rel_npc",   npc, 32'h14);
    check("st_rel_addr",  imem_addr, 32'h14);
    check("st_rel_req",   {31'b0, imem_req}, 32'h1);
    step();
    check("st_next_instr", instr, 32'h14);

    // Redirect mid-request with three wait states.
    do_reset(3, 1'b0);
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    step();
    redirect = 1'b0;
    check("rd_e3_addr",  imem_addr, 32'h0);
    check("rd_e3_req",   {31'b0, imem_req}, 32'h1);
    check("rd_e3_valid", {31'b0, valid}, 32'h0);
    step();
    check("rd_e4_addr", imem_addr, 32'h0);
    step();
    check("rd_e5_addr",  imem_addr, 32'h40);
    check("rd_e5_valid", {31'b0, valid}, 32'h0);
    check("rd_e5_instr", instr, 32'h0);
    for (int e = 6; e <= 8; e++) begin
      step();
      check("rd_wait_valid", {31'b0, valid}, 32'h0);
    end
    step();
    check("rd_tgt_instr", instr, 32'h40);
    check("rd_tgt_pc",    pc, 32'h40);
    check("rd_tgt_npc",   npc, 32'h44);
    check("rd_tgt_valid", {31'b0, valid}, 32'h1);

    // Redirect with stall while HELD: skid discarded.
    do_reset(0, 1'b0);
    for (int e = 1; e <= 3; e++) step();
    stall = 1'b1;
    step();
    check("rh_held_req", {31'b0, imem_req}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check("rh_valid", {31'b0, valid}, 32'h0);
    check("rh_instr", instr, 32'h0);
    check("rh_addr",  imem_addr, 32'h100);
    check("rh_req",   {31'b0, imem_req}, 32'h1);
    step();
    check("rh_tgt_instr", instr, 32'h100);
    check("rh_tgt_pc",    pc, 32'h100);
    check("rh_tgt_valid", {31'b0, valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
